comparator_sweep_checker: RTL
=============================

Name: comparator_sweep_checker

Overview:
- Sequential stimulus-and-check engine for the 2-bit magnitude comparator. It drives the comparator's a/b inputs and receives its G/E/L outputs.
- On start it walks every {a,b} pair exhaustively and samples G/E/L after a programmable settle time. It checks each sample against the expected relation and counts mismatches.
- Reports done/pass, error count and first failing vector, so the comparator can be self-checked in hardware rather than by waveform inspection.

Parameters:
- WIDTH, 2, operand width of a_out/b_out; vectors swept = 2^(2*WIDTH)
- SETTLE, 1, cycles (>=1) each vector is held before G/E/L are sampled

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse; begins a sweep when sampled in IDLE or DONE
- a_out  output  WIDTH  operand A to comparator
- b_out  output  WIDTH  operand B to comparator
- g_in  input  1  comparator G (a>b)
- e_in  input  1  comparator E (a==b)
- l_in  input  1  comparator L (a<b)
- busy  output  1  high in WAIT/CHECK
- done  output  1  high in DONE
- pass  output  1  valid when done: err_count==0
- err_count  output  2*WIDTH+1  number of failing vectors, saturating at all-ones
- first_err_a  output  WIDTH  a of first failing vector; 0 if none
- first_err_b  output  WIDTH  b of first failing vector; 0 if none

Behaviour:
- Reset, synchronous and active-high: state=IDLE; a_out=b_out=0; busy=done=pass=0; err_count=0; first_err_a=first_err_b=0.
- Reset mid-sweep aborts immediately to the reset values. No partial result is retained.
- IDLE, start=1: load a_out=0, b_out=0; clear err_count and first_err_*; clear the settle counter; go to WAIT.
- WAIT: hold a_out/b_out; count SETTLE cycles, then go to CHECK.
- CHECK: sample g_in/e_in/l_in at this edge. Expected values: G=(a_out>b_out), E=(a_out==b_out), L=(a_out<b_out), unsigned.
- A vector fails if any of the three bits differs. Non-one-hot outputs therefore always fail. One vector adds at most 1 to err_count.
- On the first failure only, latch first_err_a/first_err_b.
- Vector order: {a_out,b_out} treated as a 2*WIDTH-bit counter, with b_out the LSB half. b wraps from all-ones to 0 and carries into a.
- CHECK, last vector ({a,b} all-ones): go to DONE, with a_out/b_out held at all-ones. Otherwise increment {a,b} and return to WAIT.
- Latency: the vector is driven on the edge entering WAIT and is stable SETTLE full cycles before sampling.
- done rises exactly 2^(2*WIDTH)*(SETTLE+1) cycles after the edge that sampled start. Defaults: 16*2 = 32 cycles.
- DONE: done=1, pass=(err_count==0); results are held. start=1 restarts as from IDLE: done and pass drop on that edge.
- start is ignored while busy. start and rst together: rst wins.
- err_count saturates and never wraps. Width 2*WIDTH+1 cannot overflow in practice; saturation is mandatory regardless.

Optional Feature:
- COMPARATOR_SWEEP_STOP_ON_ERR_EN defined: the first failing CHECK goes straight to DONE with err_count=1. a_out/b_out stay frozen at the failing vector, equal to first_err_a/first_err_b.
- Not defined: the full sweep always runs; err_count is the total number of failing vectors.

Test Plan:
- Correct comparator, WIDTH=2, SETTLE=1, start pulse -> done high 32 cycles after start; pass=1; err_count=0; first_err_a=first_err_b=0; a_out=b_out=3.
- Comparator model with G stuck at 0 -> done, pass=0, err_count=6 (pairs with a>b), first_err_a=1, first_err_b=0.
- Comparator model returning E=1 also for a=3,b=2 (G=1,E=1) -> err_count=1, first_err_a=3, first_err_b=2.
- rst asserted at cycle 10 of a sweep, then start again -> outputs at reset values on the rst edge; new sweep from a=0,b=0 completes in 32 cycles with correct result.
- start pulsed again while busy, then in DONE -> mid-sweep pulse ignored (done still at cycle 32); DONE pulse drops done next edge and restarts from vector 0.
- With COMPARATOR_SWEEP_STOP_ON_ERR_EN, G stuck at 0 -> DONE after the 5th CHECK (vector a=1,b=0, 10 cycles); err_count=1; a_out=1; b_out=0.

Source files
------------

// File: rtl/comparator_sweep_checker.sv
// comparator_sweep_checker: sweeps every {a,b} pair into a 2-bit magnitude comparator and checks G/E/L.
// Optional COMPARATOR_SWEEP_STOP_ON_ERR_EN: stop at the first failing vector with a/b frozen on it.
module comparator_sweep_checker #(
    parameter int WIDTH  = 2,
    parameter int SETTLE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [WIDTH-1:0]   a_out,
    output logic [WIDTH-1:0]   b_out,
    input  logic               g_in,
    input  logic               e_in,
    input  logic               l_in,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2*WIDTH:0]   err_count,
    output logic [WIDTH-1:0]   first_err_a,
    output logic [WIDTH-1:0]   first_err_b
);
    localparam int VW = 2 * WIDTH;
    localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;
    localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, CHECK = 2'd2, DONE = 2'd3;
    logic [1:0]       state_q, state_d;
    logic [VW-1:0]    vec_q, vec_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [VW:0]      err_q, err_d;
    logic [WIDTH-1:0] fa_q, fa_d, fb_q, fb_d;
    logic             fail, last, settled;
    assign a_out       = vec_q[VW-1:WIDTH];
    assign b_out       = vec_q[WIDTH-1:0];
    assign busy        = state_q == WAIT || state_q == CHECK;
    assign done        = state_q == DONE;
    assign pass        = done && err_q == '0;
    assign err_count   = err_q;
    assign first_err_a = fa_q;
    assign first_err_b = fb_q;
    assign fail        = {g_in, e_in, l_in} != {a_out > b_out, a_out == b_out, a_out < b_out};
    assign last        = &vec_q;
    assign settled     = cnt_q == CW'(SETTLE - 1);
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        fa_d    = fa_q;
        fb_d    = fb_q;
        case (state_q)
            WAIT: begin
                state_d = settled ? CHECK : WAIT;
                cnt_d   = settled ? '0 : cnt_q + 1'b1;
            end
            CHECK: begin
                // err_q only reads zero before the first failure since it saturates
                if (fail) begin
                    err_d = &err_q ? err_q : err_q + 1'b1;
                    fa_d  = err_q == '0 ? a_out : fa_q;
                    fb_d  = err_q == '0 ? b_out : fb_q;
                end
`ifdef COMPARATOR_SWEEP_STOP_ON_ERR_EN
                state_d = (last || fail) ? DONE : WAIT;
                vec_d   = (last || fail) ? vec_q : vec_q + 1'b1;
`else
                state_d = last ? DONE : WAIT;
                vec_d   = last ? vec_q : vec_q + 1'b1;
`endif
            end
            default: begin
                if (start) begin
                    state_d = WAIT;
                    vec_d   = '0;
                    cnt_d   = '0;
                    err_d   = '0;
                    fa_d    = '0;
                    fb_d    = '0;
                end
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            fa_q    <= '0;
            fb_q    <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            fa_q    <= fa_d;
            fb_q    <= fb_d;
        end
    end
endmodule
